pc_redirect_ctrl: RTL and testbench

PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

---
 rtl/pc_redirect_ctrl.sv | 128 ++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_ctrl.sv
// Control-hazard unit: chooses the oldest live PC-redirect event across S2..S5,
// drives the new PC and squash mask, and remembers squashed slots as they advance.
module pc_redirect_ctrl #(
    parameter int         PC_W   = 16,
    parameter logic [2:0] PC_REG = 3'd7,
    parameter int         CNT_W  = 16,
    parameter bit         LHI_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             cnt_clr,
    input  logic [15:0]      pr2_IR,
    input  logic [15:0]      pr3_IR,
    input  logic [15:0]      pr4_IR,
    input  logic [15:0]      pr5_IR,
    input  logic [3:0]       stage_v,
    input  logic             equ,
    input  logic [PC_W-1:0]  s2_jal_tgt,
    input  logic [PC_W-1:0]  s2_lhi_val,
    input  logic [PC_W-1:0]  s3_beq_tgt,
    input  logic [PC_W-1:0]  s3_rb,
    input  logic [PC_W-1:0]  s4_alu,
    input  logic [PC_W-1:0]  s5_mem,
    output logic             redirect,
    output logic [PC_W-1:0]  redirect_pc,
    output logic [2:0]       pc_sel,
    output logic [3:0]       flush,
    output logic [CNT_W-1:0] redirect_cnt
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_ADI = 4'b0001;
    localparam logic [3:0] OP_NDU = 4'b0010;
    localparam logic [3:0] OP_LHI = 4'b0011;
    localparam logic [3:0] OP_LW  = 4'b0100;
    localparam logic [3:0] OP_LM  = 4'b0110;
    localparam logic [3:0] OP_JAL = 4'b1000;
    localparam logic [3:0] OP_JLR = 4'b1001;
    localparam logic [3:0] OP_BEQ = 4'b1100;

    localparam logic [2:0] SEL_NONE = 3'd0;
    localparam logic [2:0] SEL_JLR  = 3'd1;
    localparam logic [2:0] SEL_MEM  = 3'd2;
    localparam logic [2:0] SEL_JAL  = 3'd3;
    localparam logic [2:0] SEL_BEQ  = 3'd4;
    localparam logic [2:0] SEL_LHI  = 3'd5;
    localparam logic [2:0] SEL_ALU  = 3'd6;

    logic [3:0]       kmask_reg, kmask_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       live;
    logic [2:0]       cause;
    logic [PC_W-1:0]  tgt;
    logic [3:0]       kill;
    logic             take;
    logic             ev_mem, ev_alu, ev_beq, ev_jlr, ev_lhi, ev_jal;
    logic             s4_rtype;
    logic             unused_bits;

    // Instruction fields that never influence a redirect decision.
    assign unused_bits = ^{pr2_IR[8:0], pr3_IR[11:0], pr4_IR[11:9], pr4_IR[2], pr5_IR[8:0]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_live
            assign live[gi] = stage_v[gi] & ~kmask_reg[gi];
        end
    endgenerate

    assign s4_rtype = (pr4_IR[15:12] == OP_ADD || pr4_IR[15:12] == OP_NDU) && (pr4_IR[1:0] != 2'b11);

    assign ev_mem = live[3] && (pr5_IR[15:12] == OP_LW || pr5_IR[15:12] == OP_LM)
                    && (pr5_IR[11:9] == PC_REG);
    assign ev_alu = live[2] && ((s4_rtype && pr4_IR[5:3] == PC_REG)
                    || (pr4_IR[15:12] == OP_ADI && pr4_IR[8:6] == PC_REG));
    assign ev_beq = live[1] && (pr3_IR[15:12] == OP_BEQ) && equ;
    assign ev_jlr = live[1] && (pr3_IR[15:12] == OP_JLR);
    assign ev_lhi = LHI_EN && live[0] && (pr2_IR[15:12] == OP_LHI) && (pr2_IR[11:9] == PC_REG);
    assign ev_jal = live[0] && (pr2_IR[15:12] == OP_JAL);

    // Oldest stage wins; the squash mask covers every younger slot behind it.
    always_comb begin
        cause = SEL_NONE;
        tgt   = '0;
        kill  = 4'b0000;
        if (ev_mem) begin
            cause = SEL_MEM; tgt = s5_mem;     kill = 4'b1111;
        end else if (ev_alu) begin
            cause = SEL_ALU; tgt = s4_alu;     kill = 4'b0111;
        end else if (ev_beq) begin
            cause = SEL_BEQ; tgt = s3_beq_tgt; kill = 4'b0011;
        end else if (ev_jlr) begin
            cause = SEL_JLR; tgt = s3_rb;      kill = 4'b0011;
        end else if (ev_lhi) begin
            cause = SEL_LHI; tgt = s2_lhi_val; kill = 4'b0001;
        end else if (ev_jal) begin
            cause = SEL_JAL; tgt = s2_jal_tgt; kill = 4'b0001;
        end
    end

    assign take         = rst_n && !stall && (cause != SEL_NONE);
    assign redirect     = take;
    assign redirect_pc  = take ? tgt : '0;
    assign pc_sel       = take ? cause : SEL_NONE;
    assign flush        = take ? kill : 4'b0000;
    assign redirect_cnt = cnt_reg;

    always_comb begin
        kmask_next = {kmask_reg[2:0], 1'b0} | flush;
        cnt_next   = cnt_reg;
        if (cnt_clr)
            cnt_next = '0;
        else if (redirect && cnt_reg != {CNT_W{1'b1}})
            cnt_next = cnt_reg + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kmask_reg <= 4'b0000;
            cnt_reg   <= '0;
        end else if (!stall) begin
            kmask_reg <= kmask_next;
            cnt_reg   <= cnt_next;
        end
    end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: three parameterisations share one stimulus stream and
// are checked every cycle against a stage-level model plus directed literal cases.
module tb_pc_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, stall, cnt_clr, equ;
    logic [15:0] pr2_IR, pr3_IR, pr4_IR, pr5_IR;
    logic [3:0]  stage_v;
    logic [15:0] s2_jal_tgt, s2_lhi_val, s3_beq_tgt, s3_rb, s4_alu, s5_mem;

    logic [2:0]       red_d;
    logic [2:0][15:0] pc_d;
    logic [2:0][2:0]  sel_d;
    logic [2:0][3:0]  fl_d;
    logic [15:0]      cnt0, cnt1;
    logic [1:0]       cnt2;

    int  errors = 0;
    int  checks = 0;
    bit  chk_en = 1'b0;

    always #5 clk = ~clk;

    // u0: defaults, u1: LHI redirect disabled, u2: 2-bit counter
    pc_redirect_ctrl u0 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .cnt_clr(cnt_clr),
        .pr2_IR(pr2_IR), .pr3_IR(pr3_IR), .pr4_IR(pr4_IR), .pr5_IR(pr5_IR),
        .stage_v(stage_v), .equ(equ), .s2_jal_tgt(s2_jal_tgt), .s2_lhi_val(s2_lhi_val),
        .s3_beq_tgt(s3_beq_tgt), .s3_rb(s3_rb), .s4_alu(s4_alu), .s5_mem(s5_mem),
        .redirect(red_d[0]), .redirect_pc(pc_d[0]), .pc_sel(sel_d[0]), .flush(fl_d[0]),
        .redirect_cnt(cnt0)
    );
    pc_redirect_ctrl #(.LHI_EN(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .cnt_clr(cnt_clr),
        .pr2_IR(pr2_IR), .pr3_IR(pr3_IR), .pr4_IR(pr4_IR), .pr5_IR(pr5_IR),
        .stage_v(stage_v), .equ(equ), .s2_jal_tgt(s2_jal_tgt), .s2_lhi_val(s2_lhi_val),
        .s3_beq_tgt(s3_beq_tgt), .s3_rb(s3_rb), .s4_alu(s4_alu), .s5_mem(s5_mem),
        .redirect(red_d[1]), .redirect_pc(pc_d[1]), .pc_sel(sel_d[1]), .flush(fl_d[1]),
        .redirect_cnt(cnt1)
    );
    pc_redirect_ctrl #(.CNT_W(2)) u2 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .cnt_clr(cnt_clr),
        .pr2_IR(pr2_IR), .pr3_IR(pr3_IR), .pr4_IR(pr4_IR), .pr5_IR(pr5_IR),
        .stage_v(stage_v), .equ(equ), .s2_jal_tgt(s2_jal_tgt), .s2_lhi_val(s2_lhi_val),
        .s3_beq_tgt(s3_beq_tgt), .s3_rb(s3_rb), .s4_alu(s4_alu), .s5_mem(s5_mem),
        .redirect(red_d[2]), .redirect_pc(pc_d[2]), .pc_sel(sel_d[2]), .flush(fl_d[2]),
        .redirect_cnt(cnt2)
    );

    // Model state: dead_m[i][s] says the instruction now in stage S<s> was squashed.
    logic [5:2] dead_m [3];
    int         cnt_m  [3];

    function automatic bit lhi_of(input int i);
        return i != 1;
    endfunction

    function automatic int cmax_of(input int i);
        return (i == 2) ? 3 : 65535;
    endfunction

    function automatic int cnt_of(input int i);
        if (i == 0) return int'(cnt0);
        if (i == 1) return int'(cnt1);
        return int'(cnt2);
    endfunction

    // Walk S5 down to S2; the first live stage holding a PC-writing event decides.
    function automatic void model_eval(input int i, output logic red, output logic [15:0] pc,
                                       output logic [2:0] sel, output logic [3:0] fl, output int rs);
        logic [15:0] irs [2:5];
        irs[2] = pr2_IR; irs[3] = pr3_IR; irs[4] = pr4_IR; irs[5] = pr5_IR;
        red = 1'b0; pc = 16'h0; sel = 3'd0; fl = 4'h0; rs = 0;
        for (int s = 5; s >= 2; s--) begin
            logic [3:0]  op;
            logic [2:0]  ra, rb, rc;
            logic [1:0]  cz;
            int          code;
            logic [15:0] t;
            op = irs[s][15:12]; ra = irs[s][11:9]; rb = irs[s][8:6];
            rc = irs[s][5:3];   cz = irs[s][1:0];
            code = 0; t = 16'h0;
            if (stage_v[s-2] && !dead_m[i][s] && rs == 0) begin
                case (s)
                    5: if ((op == 4'h4 || op == 4'h6) && ra == 3'd7) begin code = 2; t = s5_mem; end
                    4: if (((op == 4'h0 || op == 4'h2) && cz != 2'd3 && rc == 3'd7) ||
                           (op == 4'h1 && rb == 3'd7)) begin code = 6; t = s4_alu; end
                    3: if (op == 4'hC && equ) begin code = 4; t = s3_beq_tgt; end
                       else if (op == 4'h9) begin code = 1; t = s3_rb; end
                    default: if (op == 4'h3 && ra == 3'd7 && lhi_of(i)) begin code = 5; t = s2_lhi_val; end
                             else if (op == 4'h8) begin code = 3; t = s2_jal_tgt; end
                endcase
                if (code != 0) begin rs = s; sel = 3'(code); pc = t; end
            end
        end
        if (rs != 0 && rst_n && !stall) begin
            red = 1'b1;
            fl  = 4'((1 << (rs - 1)) - 1);
        end else begin
            sel = 3'd0; pc = 16'h0;
        end
    endfunction

    // Slots S1..S(rs-1) are killed; one edge later they sit in S2..S(rs).
    function automatic logic [5:2] next_dead(input int i);
        logic r; logic [15:0] p; logic [2:0] sl; logic [3:0] f; int rs;
        logic [5:2] nd;
        model_eval(i, r, p, sl, f, rs);
        nd = {dead_m[i][4:2], 1'b0};
        if (r) for (int s = 2; s <= rs; s++) nd[s] = 1'b1;
        return nd;
    endfunction

    function automatic int next_cnt(input int i);
        logic r; logic [15:0] p; logic [2:0] sl; logic [3:0] f; int rs;
        model_eval(i, r, p, sl, f, rs);
        if (cnt_clr) return 0;
        if (r && cnt_m[i] < cmax_of(i)) return cnt_m[i] + 1;
        return cnt_m[i];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                dead_m[i] <= 4'b0000;
                cnt_m[i]  <= 0;
            end
        end else if (!stall) begin
            for (int i = 0; i < 3; i++) begin
                dead_m[i] <= next_dead(i);
                cnt_m[i]  <= next_cnt(i);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                logic r; logic [15:0] p; logic [2:0] sl; logic [3:0] f; int rs;
                model_eval(i, r, p, sl, f, rs);
                chk($sformatf("u%0d redirect", i), 32'(red_d[i]), 32'(r));
                chk($sformatf("u%0d redirect_pc", i), 32'(pc_d[i]), 32'(p));
                chk($sformatf("u%0d pc_sel", i), 32'(sel_d[i]), 32'(sl));
                chk($sformatf("u%0d flush", i), 32'(fl_d[i]), 32'(f));
                chk($sformatf("u%0d redirect_cnt", i), 32'(cnt_of(i)), 32'(cnt_m[i]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nops();
        pr2_IR = 16'h5000; pr3_IR = 16'h5000; pr4_IR = 16'h5000; pr5_IR = 16'h5000;
        stage_v = 4'hF; equ = 1'b0; stall = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic clear_pipe();
        repeat (5) begin step(); nops(); end
    endtask

    function automatic logic [15:0] rand_ir();
        logic [39:0] opl = 40'h0213468C95;
        logic [15:0] ir  = 16'($urandom);
        int k = $urandom_range(0, 9);
        ir[15:12] = opl[4*k +: 4];
        if ($urandom % 2 == 0) ir[11:9] = 3'd7;
        if ($urandom % 2 == 0) ir[8:6]  = 3'd7;
        if ($urandom % 2 == 0) ir[5:3]  = 3'd7;
        return ir;
    endfunction

    initial begin
        rst_n = 1'b0;
        nops();
        pr2_IR = 16'h8000;
        s2_jal_tgt = 16'h0100; s2_lhi_val = 16'h0; s3_beq_tgt = 16'h0;
        s3_rb = 16'h0; s4_alu = 16'h0; s5_mem = 16'h0;
        #12;
        chk("reset redirect", 32'(red_d[0]), 32'd0);
        chk("reset pc_sel", 32'(sel_d[0]), 32'd0);
        chk("reset redirect_pc", 32'(pc_d[0]), 32'd0);
        chk("reset flush", 32'(fl_d[0]), 32'd0);
        chk("reset cnt", 32'(cnt0), 32'd0);
        $display("txn reset: redirect=%b pc_sel=%0d cnt=%0d", red_d[0], sel_d[0], cnt0);
        step();
        rst_n = 1'b1; nops(); chk_en = 1'b1;

        // BEQ taken in S3, then the squashed slots must not redirect
        step(); nops();
        pr3_IR = 16'hC000; pr2_IR = 16'h8000; equ = 1'b1; s3_beq_tgt = 16'h0040;
        #1;
        chk("beq redirect", 32'(red_d[0]), 32'd1);
        chk("beq pc_sel", 32'(sel_d[0]), 32'd4);
        chk("beq redirect_pc", 32'(pc_d[0]), 32'h40);
        chk("beq flush", 32'(fl_d[0]), 32'b0011);
        $display("txn beq: pc_sel=%0d pc=%h flush=%b", sel_d[0], pc_d[0], fl_d[0]);
        step(); nops(); pr3_IR = 16'h8000; pr2_IR = 16'h8000;
        #1;
        chk("killed jal redirect", 32'(red_d[0]), 32'd0);
        $display("txn killed jal: redirect=%b", red_d[0]);
        step(); nops(); pr3_IR = 16'h9000; s3_rb = 16'h0300;
        #1;
        chk("killed jlr redirect", 32'(red_d[0]), 32'd0);
        step();
        #1;
        chk("live jlr pc_sel", 32'(sel_d[0]), 32'd1);
        chk("live jlr redirect_pc", 32'(pc_d[0]), 32'h300);
        $display("txn jlr: pc_sel=%0d pc=%h", sel_d[0], pc_d[0]);
        clear_pipe();
        chk("cnt after two", 32'(cnt0), 32'd2);

        // S5 load to PC beats a younger JAL
        step(); nops();
        pr5_IR = 16'h4E00; s5_mem = 16'h1234; pr2_IR = 16'h8000;
        #1;
        chk("lw pc_sel", 32'(sel_d[0]), 32'd2);
        chk("lw redirect_pc", 32'(pc_d[0]), 32'h1234);
        chk("lw flush", 32'(fl_d[0]), 32'hF);
        $display("txn lw: pc_sel=%0d pc=%h flush=%b", sel_d[0], pc_d[0], fl_d[0]);
        clear_pipe();

        // Stall holds the JAL back until released
        step(); nops(); stall = 1'b1; pr2_IR = 16'h8000; s2_jal_tgt = 16'h0200;
        #1;
        chk("stall redirect", 32'(red_d[0]), 32'd0);
        step();
        #1;
        chk("stall redirect 2", 32'(red_d[0]), 32'd0);
        chk("stall cnt", 32'(cnt0), 32'd3);
        step(); stall = 1'b0;
        #1;
        chk("unstall pc_sel", 32'(sel_d[0]), 32'd3);
        chk("unstall flush", 32'(fl_d[0]), 32'b0001);
        step(); nops();
        #1;
        chk("unstall cnt", 32'(cnt0), 32'd4);
        $display("txn stall/jal: cnt=%0d", cnt0);
        clear_pipe();

        // LHI to PC, with and without LHI_EN
        step(); nops(); pr2_IR = 16'h3E00; s2_lhi_val = 16'hBEEF;
        #1;
        chk("lhi en pc_sel", 32'(sel_d[0]), 32'd5);
        chk("lhi en redirect_pc", 32'(pc_d[0]), 32'hBEEF);
        chk("lhi dis pc_sel", 32'(sel_d[1]), 32'd0);
        chk("lhi dis redirect", 32'(red_d[1]), 32'd0);
        $display("txn lhi: en sel=%0d dis sel=%0d", sel_d[0], sel_d[1]);
        clear_pipe();

        // 2-bit counter saturation and clear-over-increment
        step(); nops(); cnt_clr = 1'b1;
        step(); nops();
        chk("clr cnt2", 32'(cnt2), 32'd0);
        for (int n = 1; n <= 5; n++) begin
            step(); nops(); pr2_IR = 16'h8000; s2_jal_tgt = 16'(n * 16);
            #1;
            chk("sat jal redirect", 32'(red_d[2]), 32'd1);
            step(); nops();
            #1;
            chk("sat cnt2", 32'(cnt2), 32'((n < 3) ? n : 3));
            $display("txn jal %0d: cnt2=%0d", n, cnt2);
        end
        step(); nops(); pr2_IR = 16'h8000; cnt_clr = 1'b1;
        #1;
        chk("clr+jal redirect", 32'(red_d[2]), 32'd1);
        step(); nops();
        #1;
        chk("clr+jal cnt2", 32'(cnt2), 32'd0);
        chk("clr+jal cnt0", 32'(cnt0), 32'd0);
        $display("txn clr+jal: cnt2=%0d cnt0=%0d", cnt2, cnt0);
        clear_pipe();

        // Asynchronous reset wipes the dead-slot memory mid-cycle
        step(); nops(); pr3_IR = 16'hC000; equ = 1'b1; s3_beq_tgt = 16'h0040;
        #1;
        chk("pre-reset beq", 32'(red_d[0]), 32'd1);
        step(); nops();
        step(); nops(); pr3_IR = 16'h9000; s3_rb = 16'h0300;
        #1;
        chk("pre-reset jlr dead", 32'(red_d[0]), 32'd0);
        chk("pre-reset cnt", 32'(cnt0), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async cnt0", 32'(cnt0), 32'd0);
        chk("async redirect", 32'(red_d[0]), 32'd0);
        chk("async flush", 32'(fl_d[0]), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post-reset jlr live", 32'(sel_d[0]), 32'd1);
        $display("txn async reset: cnt0=%0d jlr sel=%0d", cnt0, sel_d[0]);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            step();
            rst_n      = ($urandom % 300 != 0);
            stall      = ($urandom % 10 == 0);
            cnt_clr    = ($urandom % 30 == 0);
            for (int b = 0; b < 4; b++) stage_v[b] = ($urandom % 100 < 85);
            equ        = 1'($urandom);
            pr2_IR     = rand_ir(); pr3_IR = rand_ir();
            pr4_IR     = rand_ir(); pr5_IR = rand_ir();
            s2_jal_tgt = 16'($urandom); s2_lhi_val = 16'($urandom);
            s3_beq_tgt = 16'($urandom); s3_rb      = 16'($urandom);
            s4_alu     = 16'($urandom); s5_mem     = 16'($urandom);
            #1;
            $display("txn rand %0d: rst_n=%b stall=%b v=%b sel=%0d pc=%h flush=%b cnt=%0d",
                     c, rst_n, stall, stage_v, sel_d[0], pc_d[0], fl_d[0], cnt0);
        end
        step();
        rst_n = 1'b1; nops();
        step();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
